// File: rtl/seqdec_sched.sv
// seqdec_sched: round-robin sharing of one serial "00001" detector between two word requesters.
// Each granted word is flushed into the detector, shifted MSB first, and its matches are counted.
module seqdec_sched #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [1:0]       i_req_valid,
    input  logic [WIDTH-1:0] i_req_data0,
    input  logic [WIDTH-1:0] i_req_data1,
    output logic [1:0]       o_req_ack,
    output logic             o_det_data,
    input  logic             i_det_found,
    output logic             o_busy,
    output logic             o_res_valid,
    output logic             o_res_id,
    output logic [CNT_W-1:0] o_res_count
);

    localparam int               TW        = $clog2(WIDTH);
    localparam logic [TW-1:0]    TMR_FLUSH = TW'(1);
    localparam logic [TW-1:0]    TMR_SHIFT = TW'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_word;
    logic [TW-1:0]    r_tmr;
    logic             r_ptr;

    logic             w_grant;
    logic             w_gid;

    always_comb begin
        w_grant = |i_req_valid;
        case (i_req_valid)
            2'b01:   w_gid = 1'b0;
            2'b10:   w_gid = 1'b1;
            default: w_gid = r_ptr;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_word      <= '0;
            r_tmr       <= '0;
            r_ptr       <= 1'b0;
            o_req_ack   <= 2'b00;
            o_det_data  <= 1'b1;
            o_busy      <= 1'b0;
            o_res_valid <= 1'b0;
            o_res_id    <= 1'b0;
            o_res_count <= '0;
        end else begin
            o_req_ack   <= 2'b00;
            o_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    o_det_data <= 1'b1;
                    if (w_grant) begin
                        r_word      <= w_gid ? i_req_data1 : i_req_data0;
                        o_res_id    <= w_gid;
                        o_res_count <= '0;
                        o_req_ack   <= w_gid ? 2'b10 : 2'b01;
                        o_busy      <= 1'b1;
                        r_tmr       <= TMR_FLUSH;
                        r_state     <= S_FLUSH;
                        if (&i_req_valid)
                            r_ptr <= ~r_ptr;
                    end
                end
                S_FLUSH: begin
                    // Flush-induced found pulses are not part of the word.
                    if (r_tmr == '0) begin
                        o_det_data <= r_word[WIDTH-1];
                        r_word     <= {r_word[WIDTH-2:0], 1'b0};
                        r_tmr      <= TMR_SHIFT;
                        r_state    <= S_SHIFT;
                    end else begin
                        r_tmr <= r_tmr - TW'(1);
                    end
                end
                S_SHIFT: begin
                    // First SHIFT cycle still shows the response to the last flush bit.
                    if (r_tmr != TMR_SHIFT && i_det_found && o_res_count != CNT_MAX)
                        o_res_count <= o_res_count + CNT_W'(1);
                    if (r_tmr == '0) begin
                        o_det_data <= 1'b1;
                        r_state    <= S_DRAIN;
                    end else begin
                        o_det_data <= r_word[WIDTH-1];
                        r_word     <= {r_word[WIDTH-2:0], 1'b0};
                        r_tmr      <= r_tmr - TW'(1);
                    end
                end
                S_DRAIN: begin
                    if (i_det_found && o_res_count != CNT_MAX)
                        o_res_count <= o_res_count + CNT_W'(1);
                    o_res_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    o_busy     <= 1'b0;
                    o_det_data <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seqdec_sched.sv
// Directed bench for seqdec_sched: two instances (16/5 and 32/2), each driving a
// behavioural registered "00001" detector.
module tb_seqdec_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic [1:0]  req_valid;
    logic [15:0] d0, d1;
    logic [1:0]  ack;
    logic        det_data, det_found;
    logic        busy, res_valid, res_id;
    logic [4:0]  res_count;

    // Instance B: WIDTH=32, CNT_W=2
    logic [1:0]  b_valid;
    logic [31:0] b_d0, b_d1;
    logic [1:0]  b_ack;
    logic        b_det_data, b_det_found;
    logic        b_busy, b_res_valid, b_res_id;
    logic [1:0]  b_res_count;

    seqdec_sched #(.WIDTH(16), .CNT_W(5)) u_dut_a (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_req_valid (req_valid),
        .i_req_data0 (d0),
        .i_req_data1 (d1),
        .o_req_ack   (ack),
        .o_det_data  (det_data),
        .i_det_found (det_found),
        .o_busy      (busy),
        .o_res_valid (res_valid),
        .o_res_id    (res_id),
        .o_res_count (res_count)
    );

    seqdec_sched #(.WIDTH(32), .CNT_W(2)) u_dut_b (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_req_valid (b_valid),
        .i_req_data0 (b_d0),
        .i_req_data1 (b_d1),
        .o_req_ack   (b_ack),
        .o_det_data  (b_det_data),
        .i_det_found (b_det_found),
        .o_busy      (b_busy),
        .o_res_valid (b_res_valid),
        .o_res_id    (b_res_id),
        .o_res_count (b_res_count)
    );

    // Registered detector models: found rises the cycle after the final '1' of 00001 is sampled.
    logic [3:0] hist_a, hist_b;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_a    <= 4'hF;
            det_found <= 1'b0;
        end else begin
            hist_a    <= {hist_a[2:0], det_data};
            det_found <= ({hist_a, det_data} == 5'b00001);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_b      <= 4'hF;
            b_det_found <= 1'b0;
        end else begin
            hist_b      <= {hist_b[2:0], b_det_data};
            b_det_found <= ({hist_b, b_det_data} == 5'b00001);
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one word on instance A from idle; check ack, latency, id, count and return to idle.
    task automatic run_word(input logic [1:0] vld, input logic [15:0] w0, input logic [15:0] w1,
                            input logic [1:0] exp_ack, input logic exp_id, input int exp_cnt,
                            input string tag);
        bit seen;
        int lat;
        @(negedge clk);
        d0 = w0;
        d1 = w1;
        req_valid = vld;
        @(negedge clk);
        check_vec($sformatf("%s_ack", tag), {30'd0, ack}, {30'd0, exp_ack});
        check_vec($sformatf("%s_busy", tag), {31'd0, busy}, 32'd1);
        req_valid = 2'b00;
        d0 = ~w0;
        d1 = ~w1;
        seen = 0;
        lat = 0;
        for (int c = 2; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (res_valid) begin
                seen = 1;
                lat  = c;
            end
        end
        check_vec($sformatf("%s_lat", tag), lat, 32'd20);
        check_vec($sformatf("%s_id", tag), {31'd0, res_id}, {31'd0, exp_id});
        check_vec($sformatf("%s_cnt", tag), {27'd0, res_count}, exp_cnt);
        @(negedge clk);
        check_vec($sformatf("%s_idle", tag), {30'd0, busy, res_valid}, 32'd0);
        check_vec($sformatf("%s_hold", tag), {26'd0, res_id, res_count}, {26'd0, exp_id, 5'(exp_cnt)});
    endtask

    initial begin
        int n_ack, n_res, last_c, lat;
        bit seen;

        rst = 1'b1;
        req_valid = 2'b00;
        d0 = '0;
        d1 = '0;
        b_valid = 2'b00;
        b_d0 = '0;
        b_d1 = '0;

        @(negedge clk);
        check_vec("rst_ack", {30'd0, ack}, 32'd0);
        check_vec("rst_busy", {31'd0, busy}, 32'd0);
        check_vec("rst_resv", {31'd0, res_valid}, 32'd0);
        check_vec("rst_id_cnt", {26'd0, res_id, res_count}, 32'd0);
        check_vec("rst_det", {31'd0, det_data}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        run_word(2'b01, 16'h0840, 16'h1234, 2'b01, 1'b0, 2, "w0840");
        run_word(2'b10, 16'h0001, 16'hFFFF, 2'b10, 1'b1, 0, "wFFFF");
        run_word(2'b10, 16'h0840, 16'h0001, 2'b10, 1'b1, 1, "w0001");
        run_word(2'b10, 16'h0001, 16'h0000, 2'b10, 1'b1, 0, "w0000");
        run_word(2'b01, 16'h0000, 16'h0840, 2'b01, 1'b0, 0, "iso_a");
        run_word(2'b01, 16'h8000, 16'h0840, 2'b01, 1'b0, 0, "iso_b");

        // Both requesters held: strict alternation at one word per 21 cycles.
        @(negedge clk);
        d0 = 16'h0840;
        d1 = 16'h0001;
        req_valid = 2'b11;
        n_ack = 0;
        n_res = 0;
        last_c = 0;
        for (int c = 1; c <= 120 && n_res < 4; c++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                check_vec($sformatf("rr_ack%0d", n_ack), {30'd0, ack},
                          (n_ack % 2 == 0) ? 32'd1 : 32'd2);
                n_ack++;
                if (n_ack == 4)
                    req_valid = 2'b00;
            end
            if (res_valid) begin
                check_vec($sformatf("rr_id%0d", n_res), {31'd0, res_id}, n_res % 2);
                check_vec($sformatf("rr_cnt%0d", n_res), {27'd0, res_count},
                          (n_res % 2 == 0) ? 32'd2 : 32'd1);
                if (n_res > 0)
                    check_vec($sformatf("rr_gap%0d", n_res), c - last_c, 32'd21);
                last_c = c;
                n_res++;
            end
        end
        check_vec("rr_nres", n_res, 32'd4);
        check_vec("rr_nack", n_ack, 32'd4);
        @(negedge clk);

        // Reset in the middle of SHIFT drops the word.
        @(negedge clk);
        d1 = 16'h0000;
        req_valid = 2'b10;
        @(negedge clk);
        check_vec("mid_ack", {30'd0, ack}, 32'd2);
        req_valid = 2'b00;
        repeat (5) @(negedge clk);
        check_vec("mid_det_pre", {31'd0, det_data}, 32'd0);
        check_vec("mid_id_pre", {31'd0, res_id}, 32'd1);
        rst = 1'b1;
        #1;
        check_vec("mid_rst_outs", {26'd0, ack, busy, res_valid, res_id, res_count[0]}, 32'd0);
        check_vec("mid_rst_cnt", {27'd0, res_count}, 32'd0);
        check_vec("mid_rst_det", {31'd0, det_data}, 32'd1);
        req_valid = 2'b11;
        d0 = 16'h0840;
        d1 = 16'hFFFF;
        @(negedge clk);
        check_vec("mid_rst_resv", {31'd0, res_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_vec("post_rst_ack", {30'd0, ack}, 32'd1);
        req_valid = 2'b00;
        seen = 0;
        lat = 0;
        for (int c = 2; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (res_valid) begin
                seen = 1;
                lat  = c;
            end
        end
        check_vec("post_rst_lat", lat, 32'd20);
        check_vec("post_rst_id", {31'd0, res_id}, 32'd0);
        check_vec("post_rst_cnt", {27'd0, res_count}, 32'd2);
        @(negedge clk);

        // Wide instance: count saturates at 3.
        @(negedge clk);
        b_d0 = 32'h08421084;
        b_valid = 2'b01;
        @(negedge clk);
        check_vec("w32_ack", {30'd0, b_ack}, 32'd1);
        b_valid = 2'b00;
        b_d0 = 32'h0;
        seen = 0;
        lat = 0;
        for (int c = 2; c <= 60 && !seen; c++) begin
            @(negedge clk);
            if (b_res_valid) begin
                seen = 1;
                lat  = c;
            end
        end
        check_vec("w32_lat", lat, 32'd36);
        check_vec("w32_id", {31'd0, b_res_id}, 32'd0);
        check_vec("w32_cnt", {30'd0, b_res_count}, 32'd3);
        @(negedge clk);
        check_vec("w32_idle", {31'd0, b_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
